// File: rtl/sound_event_arbiter.sv
// Buzzer arbiter: latches game audio events, grants them in fixed priority
// (over > hit1 > hit2 > eat) and plays one timed square-wave tone at a time.
module sound_event_arbiter #(
  parameter int unsigned HP_EAT   = 12500,
  parameter int unsigned HP_HIT   = 25000,
  parameter int unsigned HP_OVER  = 50000,
  parameter int unsigned DUR_EAT  = 2500000,
  parameter int unsigned DUR_HIT  = 5000000,
  parameter int unsigned DUR_OVER = 12500000,
  parameter int unsigned GAP_CYC  = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       eat_req,
  input  logic       hit1_req,
  input  logic       hit2_req,
  input  logic       over_lvl,
  input  logic       mute,
  output logic       sound_o,
  output logic       busy,
  output logic [1:0] active_id,
  output logic [7:0] drop_cnt
);

  localparam int unsigned HP_MAX0  = (HP_EAT > HP_HIT) ? HP_EAT : HP_HIT;
  localparam int unsigned HP_MAX   = (HP_MAX0 > HP_OVER) ? HP_MAX0 : HP_OVER;
  localparam int unsigned DUR_MAX0 = (DUR_EAT > DUR_HIT) ? DUR_EAT : DUR_HIT;
  localparam int unsigned DUR_MAX1 = (DUR_MAX0 > DUR_OVER) ? DUR_MAX0 : DUR_OVER;
  localparam int unsigned DUR_MAX  = (DUR_MAX1 > GAP_CYC) ? DUR_MAX1 : GAP_CYC;
  localparam int unsigned HW       = (HP_MAX > 1) ? $clog2(HP_MAX) : 1;
  localparam int unsigned DW       = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;

  localparam logic [1:0] ID_NONE = 2'd0;
  localparam logic [1:0] ID_EAT  = 2'd1;
  localparam logic [1:0] ID_HIT  = 2'd2;
  localparam logic [1:0] ID_OVER = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  state_t        state, state_nx;
  logic [3:0]    pend, pend_nx;        // {over, hit2, hit1, eat}
  logic          over_q;
  logic          lock, lock_nx;
  logic [1:0]    tone_id, tone_id_nx;
  logic          tone, tone_nx;
  logic [DW-1:0] dcnt, dcnt_nx;        // tone duration, then reused for the gap
  logic [HW-1:0] hcnt, hcnt_nx;
  logic          busy_nx, sound_nx;
  logic [1:0]    id_nx;
  logic [7:0]    drop_nx;

  logic          rise, fall, grant, preempt, clear_all, block;
  logic [1:0]    grant_id;
  logic [3:0]    req, take, keep, drop_vec;
  logic [2:0]    drops;
  logic [8:0]    drop_sum;

  function automatic logic [DW-1:0] dur_of(input logic [1:0] id);
    case (id)
      ID_OVER: return DW'(DUR_OVER - 1);
      ID_HIT:  return DW'(DUR_HIT - 1);
      default: return DW'(DUR_EAT - 1);
    endcase
  endfunction

  function automatic logic [HW-1:0] hp_of(input logic [1:0] id);
    case (id)
      ID_OVER: return HW'(HP_OVER - 1);
      ID_HIT:  return HW'(HP_HIT - 1);
      default: return HW'(HP_EAT - 1);
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pend      <= '0;
      over_q    <= 1'b0;
      lock      <= 1'b0;
      tone_id   <= ID_NONE;
      tone      <= 1'b0;
      dcnt      <= '0;
      hcnt      <= '0;
      sound_o   <= 1'b0;
      busy      <= 1'b0;
      active_id <= ID_NONE;
      drop_cnt  <= '0;
    end else begin
      state     <= state_nx;
      pend      <= pend_nx;
      over_q    <= over_lvl;
      lock      <= lock_nx;
      tone_id   <= tone_id_nx;
      tone      <= tone_nx;
      dcnt      <= dcnt_nx;
      hcnt      <= hcnt_nx;
      sound_o   <= sound_nx;
      busy      <= busy_nx;
      active_id <= id_nx;
      drop_cnt  <= drop_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    tone_id_nx = tone_id;
    tone_nx    = tone;
    dcnt_nx    = dcnt;
    hcnt_nx    = hcnt;
    lock_nx    = lock;
    grant      = 1'b0;
    grant_id   = ID_NONE;
    take       = 4'b0000;
    preempt    = 1'b0;
    clear_all  = 1'b0;
    rise       = over_lvl & ~over_q;
    fall       = ~over_lvl & over_q;
    req        = {rise, hit2_req, hit1_req, eat_req};

    if (fall) begin
      // new game: abandon everything and return to IDLE silently
      state_nx  = S_IDLE;
      tone_nx   = 1'b0;
      clear_all = 1'b1;
      lock_nx   = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pend[3]) begin
            grant = 1'b1; grant_id = ID_OVER; take[3] = 1'b1;
          end else if (pend[1]) begin
            grant = 1'b1; grant_id = ID_HIT; take[1] = 1'b1;
          end else if (pend[2]) begin
            grant = 1'b1; grant_id = ID_HIT; take[2] = 1'b1;
          end else if (pend[0]) begin
            grant = 1'b1; grant_id = ID_EAT; take[0] = 1'b1;
          end
        end
        S_PLAY: begin
          if (pend[3] && tone_id != ID_OVER) begin
            grant = 1'b1; grant_id = ID_OVER; take[3] = 1'b1; preempt = 1'b1;
          end else if (dcnt == '0) begin
            state_nx = S_GAP;
            tone_nx  = 1'b0;
            dcnt_nx  = DW'(GAP_CYC - 1);
          end else begin
            dcnt_nx = dcnt - DW'(1);
            if (hcnt == '0) begin
              tone_nx = ~tone;
              hcnt_nx = hp_of(tone_id);
            end else begin
              hcnt_nx = hcnt - HW'(1);
            end
          end
        end
        S_GAP: begin
          if (pend[3]) begin
            grant = 1'b1; grant_id = ID_OVER; take[3] = 1'b1;
          end else if (dcnt == '0) begin
            state_nx = S_IDLE;
            // the game-over sequence is finished: silence until the next game
            if (tone_id == ID_OVER) begin
              clear_all = 1'b1;
              lock_nx   = 1'b1;
            end
          end else begin
            dcnt_nx = dcnt - DW'(1);
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end

    if (grant) begin
      state_nx   = S_PLAY;
      tone_id_nx = grant_id;
      tone_nx    = 1'b0;
      dcnt_nx    = dur_of(grant_id);
      hcnt_nx    = hp_of(grant_id);
    end

    // a bit consumed this edge may be re-armed by a simultaneous request
    block = lock | clear_all;
    keep  = pend & ~take;
    if (block) begin
      pend_nx[2:0]  = 3'b000;
      drop_vec[2:0] = req[2:0];
    end else begin
      pend_nx[2:0]  = keep[2:0] | req[2:0];
      drop_vec[2:0] = keep[2:0] & req[2:0];
    end
    pend_nx[3]  = clear_all ? 1'b0 : (keep[3] | req[3]);
    drop_vec[3] = keep[3] & req[3] & ~clear_all;

    drops    = 3'(drop_vec[0]) + 3'(drop_vec[1]) + 3'(drop_vec[2]) +
               3'(drop_vec[3]) + 3'(preempt);
    drop_sum = 9'(drop_cnt) + 9'(drops);
    drop_nx  = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    busy_nx  = (state_nx != S_IDLE);
    id_nx    = (state_nx == S_PLAY) ? tone_id_nx : ID_NONE;
    sound_nx = tone_nx & ~mute;
  end

endmodule

// File: tb/tb_sound_event_arbiter.sv
// Bench for sound_event_arbiter: time-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_sound_event_arbiter;

  localparam int HPE = 2, HPH = 3, HPO = 4;
  localparam int DRE = 20, DRH = 30, DRO = 40, GAP = 5;

  logic       clk, rst, eat_req, hit1_req, hit2_req, over_lvl, mute;
  logic       sound_o, busy;
  logic [1:0] active_id;
  logic [7:0] drop_cnt;

  int checks = 0;
  int failures = 0;
  int ecount = 0;
  int base = 0;

  sound_event_arbiter #(
    .HP_EAT(HPE), .HP_HIT(HPH), .HP_OVER(HPO),
    .DUR_EAT(DRE), .DUR_HIT(DRH), .DUR_OVER(DRO), .GAP_CYC(GAP)
  ) dut (
    .clk(clk), .rst(rst), .eat_req(eat_req), .hit1_req(hit1_req),
    .hit2_req(hit2_req), .over_lvl(over_lvl), .mute(mute),
    .sound_o(sound_o), .busy(busy), .active_id(active_id), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) ecount <= ecount + 1;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: occupancy is described by grant edge and class; tone,
  // gap and idle windows follow from elapsed edges.
  int m_t, m_start, m_cls, m_drops;
  bit m_active, m_lock, m_prev;
  bit m_pend [4];        // 0 eat, 1 hit1, 2 hit2, 3 over
  int exp_sound, exp_busy, exp_id, exp_drop;

  function automatic int dur_of(input int c);
    return (c == 3) ? DRO : (c == 2) ? DRH : DRE;
  endfunction
  function automatic int hp_of(input int c);
    return (c == 3) ? HPO : (c == 2) ? HPH : HPE;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit req [4];
    bit rise, fall;
    int x, ph, g, a;
    if (rst) begin
      m_t = 0; m_start = 0; m_cls = 0; m_drops = 0;
      m_active = 0; m_lock = 0; m_prev = 0;
      for (int i = 0; i < 4; i++) m_pend[i] = 0;
      exp_sound = 0; exp_busy = 0; exp_id = 0; exp_drop = 0;
    end else begin
      rise = over_lvl && !m_prev;
      fall = !over_lvl && m_prev;
      m_prev = over_lvl;
      req[0] = eat_req; req[1] = hit1_req; req[2] = hit2_req; req[3] = rise;
      m_t++;
      x  = m_t - 1 - m_start;
      ph = !m_active ? 0 : (x < dur_of(m_cls)) ? 1 : 2;
      g  = -1;
      if (fall) begin
        for (int i = 0; i < 4; i++) begin
          if (req[i]) m_drops++;
          m_pend[i] = 0;
        end
        m_active = 0;
        m_lock   = 0;
      end else begin
        if (ph == 0) begin
          if (m_pend[3]) g = 3;
          else if (m_pend[1]) g = 1;
          else if (m_pend[2]) g = 2;
          else if (m_pend[0]) g = 0;
        end else if (m_pend[3] && (ph == 2 || m_cls != 3)) begin
          g = 3;
          if (ph == 1) m_drops++;
        end else if (ph == 2 && x == dur_of(m_cls) + GAP - 1) begin
          m_active = 0;
          if (m_cls == 3) begin
            m_lock = 1;
            for (int i = 0; i < 4; i++) m_pend[i] = 0;
          end
        end
        if (g >= 0) begin
          m_pend[g] = 0;
          m_active  = 1;
          m_cls     = (g == 3) ? 3 : (g == 0) ? 1 : 2;
          m_start   = m_t;
        end
        for (int i = 0; i < 4; i++) begin
          if (req[i]) begin
            if ((m_lock && i != 3) || m_pend[i]) m_drops++;
            else m_pend[i] = 1;
          end
        end
      end
      exp_sound = 0; exp_busy = 0; exp_id = 0;
      if (m_active) begin
        a = m_t - m_start;
        exp_busy = 1;
        if (a < dur_of(m_cls)) begin
          exp_id    = m_cls;
          exp_sound = (((a / hp_of(m_cls)) % 2) == 1 && !mute) ? 1 : 0;
        end
      end
      exp_drop = (m_drops > 255) ? 255 : m_drops;
    end
  end

  always @(negedge clk) begin
    if (ecount > 0) begin
      check("cyc_sound_o", int'(sound_o), exp_sound);
      check("cyc_busy", int'(busy), exp_busy);
      check("cyc_active_id", int'(active_id), exp_id);
      check("cyc_drop_cnt", int'(drop_cnt), exp_drop);
    end
  end

  task automatic at(input int k);
    while (ecount < base + k) @(negedge clk);
  endtask

  task automatic drive(input int mask, input logic v);
    if ((mask & 1) != 0) eat_req = v;
    if ((mask & 2) != 0) hit1_req = v;
    if ((mask & 4) != 0) hit2_req = v;
  endtask

  // request sampled at the next edge, which becomes edge 0
  task automatic start(input int mask);
    drive(mask, 1'b1);
    @(negedge clk);
    drive(mask, 1'b0);
    base = ecount;
  endtask

  task automatic pulse_at(input int mask, input int k);
    at(k - 1);
    drive(mask, 1'b1);
    @(negedge clk);
    drive(mask, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; eat_req = 1'b0; hit1_req = 1'b0; hit2_req = 1'b0;
    over_lvl = 1'b0; mute = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sound_o", int'(sound_o), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_active_id", int'(active_id), 0);
    check("rst_drop_cnt", int'(drop_cnt), 0);
    rst = 1'b0;
    @(negedge clk);

    // single eat tone
    start(1);
    check("eat_pending_busy", int'(busy), 0);
    at(1);  check("eat_grant_id", int'(active_id), 1);
            check("eat_grant_sound", int'(sound_o), 0);
    at(3);  check("eat_first_rise", int'(sound_o), 1);
    at(20); check("eat_last_play_id", int'(active_id), 1);
    at(21); check("eat_gap_id", int'(active_id), 0);
            check("eat_gap_busy", int'(busy), 1);
    at(25); check("eat_gap_end_busy", int'(busy), 1);
    at(26); check("eat_idle_busy", int'(busy), 0);
            check("eat_drop_cnt", int'(drop_cnt), 0);

    // simultaneous hit1/hit2/eat served in priority order
    start(7);
    at(1);  check("prio_hit1_id", int'(active_id), 2);
    at(4);  check("prio_hit_rise", int'(sound_o), 1);
    at(30); check("prio_hit1_end_id", int'(active_id), 2);
    at(31); check("prio_hit1_gap_id", int'(active_id), 0);
    at(36); check("prio_idle1_busy", int'(busy), 0);
    at(37); check("prio_hit2_id", int'(active_id), 2);
    at(72); check("prio_idle2_busy", int'(busy), 0);
    at(73); check("prio_eat_id", int'(active_id), 1);
    at(98); check("prio_done_busy", int'(busy), 0);

    // repeated eat requests during an eat tone
    start(1);
    pulse_at(1, 5);
    pulse_at(1, 8);
    pulse_at(1, 11);
    at(12); check("eat3_drop_cnt", int'(drop_cnt), 2);
    at(26); check("eat3_idle_busy", int'(busy), 0);
    at(27); check("eat3_second_id", int'(active_id), 1);
    at(52); check("eat3_done_busy", int'(busy), 0);

    // game over preempts a hit tone, then locks out further requests
    start(2);
    at(9);  over_lvl = 1'b1;
    at(10); check("over_pend_id", int'(active_id), 2);
    at(11); check("over_preempt_id", int'(active_id), 3);
            check("over_preempt_drop", int'(drop_cnt), 3);
    at(14); check("over_low_phase", int'(sound_o), 0);
    at(15); check("over_first_rise", int'(sound_o), 1);
    at(50); check("over_last_id", int'(active_id), 3);
    at(51); check("over_gap_id", int'(active_id), 0);
    at(56); check("over_idle_busy", int'(busy), 0);
    pulse_at(1, 60);
            check("lock_eat_drop", int'(drop_cnt), 4);
    at(61); check("lock_eat_busy", int'(busy), 0);

    // new game ends the lockout; a fall mid over-tone silences at once
    over_lvl = 1'b0;
    at(62); check("newgame_busy", int'(busy), 0);
    at(63); over_lvl = 1'b1;
    at(65); check("over2_id", int'(active_id), 3);
    at(77); check("over2_high", int'(sound_o), 1);
    over_lvl = 1'b0;
    eat_req = 1'b1;
    @(negedge clk);
    eat_req = 1'b0;
    check("fall_busy", int'(busy), 0);
    check("fall_sound", int'(sound_o), 0);
    check("fall_id", int'(active_id), 0);
    check("fall_req_drop", int'(drop_cnt), 5);
    pulse_at(1, 79);
    at(80);  check("post_eat_id", int'(active_id), 1);
    at(82);  check("post_eat_rise", int'(sound_o), 1);
    at(99);  check("post_eat_last_id", int'(active_id), 1);
    at(100); check("post_eat_gap_busy", int'(busy), 1);
    at(105); check("post_eat_idle", int'(busy), 0);

    // mute hides the tone only; async reset mid-tone clears everything
    mute = 1'b1;
    start(1);
    at(1); check("mute_id", int'(active_id), 1);
    at(3); check("mute_sound", int'(sound_o), 0);
           check("mute_busy", int'(busy), 1);
    at(6); mute = 1'b0;
    at(8); check("unmute_sound", int'(sound_o), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_sound", int'(sound_o), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_id", int'(active_id), 0);
    check("arst_drop", int'(drop_cnt), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
